// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the segment encoder and the scan-capture block.
// Segment bit order is {g,f,e,d,c,b,a}, bit 0 = a, active high.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS_DEFAULT = 4;

    localparam logic [6:0] SEG_BLANK   = 7'h00;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    // Index i holds the segment pattern for decimal digit i.
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    typedef enum logic [0:0] {
        StEmpty,
        StCollect
    } cap_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decoder; unknown patterns (blank included)
// decode to BCD_INVALID with err set.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = BCD_INVALID;
        err = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (seg != SEG_BLANK && seg == SEG_DIGIT[i]) begin
                bcd = 4'(i);
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed seven-segment display scan into a BCD frame once every
// digit position has been seen stable for STABLE_CYCLES consecutive samples.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NUM_DIGITS    = NUM_DIGITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    overrun
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

    // Sample stage and run tracking
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] en_q;
    logic [3:0]            run_q, run_d;
    logic                  written_q, written_d;
    logic                  same_sample;
    logic                  capturable;
    logic                  slot_wr;

    // Frame assembly
    cap_state_t                       state_q, state_d;
    logic [NUM_DIGITS-1:0]            mask_q, mask_d;
    logic [NUM_DIGITS-1:0]            mask_wr;
    logic [NUM_DIGITS-1:0][3:0]       slot_bcd_q, slot_bcd_d;
    logic [NUM_DIGITS-1:0]            slot_err_q, slot_err_d;
    logic                             frame_full;
    logic                             accept;

    // Output buffer
    logic                             valid_q, valid_d;
    logic [NUM_DIGITS-1:0][3:0]       obcd_q, obcd_d;
    logic [NUM_DIGITS-1:0]            oerr_q, oerr_d;
    logic                             overrun_q, overrun_d;

    logic [3:0] dec_bcd;
    logic       dec_err;

    seg7_pattern_decode u_decode (
        .seg (seg_q),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    always_comb begin
        same_sample = (seg == seg_q) && (dig_en == en_q);
        if (!same_sample) begin
            run_d = 4'd1;
        end else if (run_q >= RUN_MAX) begin
            run_d = RUN_MAX;
        end else begin
            run_d = run_q + 4'd1;
        end

        capturable = ($countones(en_q) == 1);
        // Fires once per run: the cycle after the counter has reached the threshold.
        slot_wr    = (run_q == RUN_MAX) && !written_q && capturable;

        if (!same_sample) begin
            written_d = 1'b0;
        end else if (slot_wr) begin
            written_d = 1'b1;
        end else begin
            written_d = written_q;
        end
    end

    always_comb begin
        slot_bcd_d = slot_bcd_q;
        slot_err_d = slot_err_q;
        mask_wr    = (state_q == StEmpty) ? '0 : mask_q;
        if (slot_wr) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (en_q[i]) begin
                    slot_bcd_d[i] = dec_bcd;
                    slot_err_d[i] = dec_err;
                    mask_wr[i]    = 1'b1;
                end
            end
        end

        frame_full = &mask_wr;
        accept     = !valid_q || out_ready;
        mask_d     = frame_full ? '0 : mask_wr;
        state_d    = (mask_d != '0) ? StCollect : StEmpty;

        valid_d   = valid_q;
        obcd_d    = obcd_q;
        oerr_d    = oerr_q;
        overrun_d = overrun_q;
        if (frame_full && accept) begin
            valid_d = 1'b1;
            obcd_d  = slot_bcd_d;
            oerr_d  = slot_err_d;
        end else if (frame_full) begin
            overrun_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            en_q       <= '0;
            run_q      <= '0;
            written_q  <= 1'b0;
            state_q    <= StEmpty;
            mask_q     <= '0;
            slot_bcd_q <= '0;
            slot_err_q <= '0;
            valid_q    <= 1'b0;
            obcd_q     <= '0;
            oerr_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            seg_q      <= seg;
            en_q       <= dig_en;
            run_q      <= run_d;
            written_q  <= written_d;
            state_q    <= state_d;
            mask_q     <= mask_d;
            slot_bcd_q <= slot_bcd_d;
            slot_err_q <= slot_err_d;
            valid_q    <= valid_d;
            obcd_q     <= obcd_d;
            oerr_q     <= oerr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_valid = valid_q;
    assign out_bcd   = obcd_q;
    assign out_err   = oerr_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: scoreboard of expected frames,
// popped on each out_valid & out_ready handshake.
module tb_seg7_scan_capture;

    localparam int unsigned ND = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg;
    logic [ND-1:0] dig_en;
    logic          out_ready;
    logic          out_valid;
    logic [4*ND-1:0] out_bcd;
    logic [ND-1:0] out_err;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    logic [4*ND+ND-1:0] exp_q [$];

    logic [6:0] pat [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    seg7_scan_capture #(
        .STABLE_CYCLES (4),
        .NUM_DIGITS    (ND)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg       (seg),
        .dig_en    (dig_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [4*ND+ND-1:0] e;
            checks++;
            frames++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: got bcd=%h err=%b, required no frame",
                         out_bcd, out_err);
            end else begin
                e = exp_q.pop_front();
                if ({out_bcd, out_err} !== e) begin
                    errors++;
                    $display("FAIL frame: got bcd=%h err=%b, required bcd=%h err=%b",
                             out_bcd, out_err, e[4*ND+ND-1:ND], e[ND-1:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show_digit(input int pos, input logic [6:0] p, input int hold);
        seg    = p;
        dig_en = ND'(1) << pos;
        tick(hold);
    endtask

    task automatic idle(input int n);
        seg    = 7'h00;
        dig_en = '0;
        tick(n);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
        show_digit(0, p0, 6);
        show_digit(1, p1, 6);
        show_digit(2, p2, 6);
        show_digit(3, p3, 6);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        out_ready = 1'b0;
        seg = 7'h00;
        dig_en = '0;
        tick(2);
        checks++;
        if (out_valid !== 1'b0 || out_bcd !== '0 || out_err !== '0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b bcd=%h err=%b ovr=%b, required all zero",
                     out_valid, out_bcd, out_err, overrun);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic;
        int f0;
        out_ready = 1'b1;
        f0 = frames;
        exp_q.push_back({16'h1234, 4'b0000});
        scan(pat[4], pat[3], pat[2], pat[1]);
        idle(3);
        checks++;
        if (frames - f0 !== 1) begin
            errors++;
            $display("FAIL basic_frame_count: got %0d, required 1", frames - f0);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_cleared: got %b, required 0", out_valid);
        end
    endtask

    task automatic test_latency;
        int lat;
        out_ready = 1'b1;
        lat = -1;
        exp_q.push_back({16'h0987, 4'b0000});
        show_digit(0, pat[7], 6);
        show_digit(1, pat[8], 6);
        show_digit(2, pat[9], 6);
        seg = pat[0];
        dig_en = 4'b1000;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (lat < 0 && out_valid === 1'b1) lat = k;
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL latency: got %0d edges, required 5", lat);
        end
        idle(3);
    endtask

    task automatic test_short;
        int f0;
        out_ready = 1'b1;
        f0 = frames;
        show_digit(0, pat[5], 6);
        show_digit(1, pat[6], 6);
        show_digit(2, pat[7], 3);
        show_digit(3, pat[8], 6);
        checks++;
        if (frames != f0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_no_frame: got frames=%0d v=%b, required 0 and 0",
                     frames - f0, out_valid);
        end
        checks++;
        if (dut.mask_q !== 4'b1011) begin
            errors++;
            $display("FAIL short_mask: got %b, required 1011", dut.mask_q);
        end
        exp_q.push_back({16'h8765, 4'b0000});
        show_digit(2, pat[7], 6);
        idle(3);
        checks++;
        if (frames - f0 !== 1) begin
            errors++;
            $display("FAIL short_frame_count: got %0d, required 1", frames - f0);
        end
    endtask

    task automatic test_blank;
        int f0;
        out_ready = 1'b1;
        f0 = frames;
        exp_q.push_back({16'h70F9, 4'b0010});
        scan(pat[9], 7'h00, pat[0], pat[7]);
        idle(3);
        checks++;
        if (frames - f0 !== 1) begin
            errors++;
            $display("FAIL blank_frame_count: got %0d, required 1", frames - f0);
        end
    endtask

    task automatic test_bad_en;
        seg = pat[0];
        dig_en = 4'b0011;
        tick(10);
        checks++;
        if (dut.mask_q !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_hot_no_write: got mask=%b v=%b, required 0000 0",
                     dut.mask_q, out_valid);
        end
        seg = pat[1];
        dig_en = 4'b0000;
        tick(10);
        checks++;
        if (dut.mask_q !== '0) begin
            errors++;
            $display("FAIL zero_en_no_write: got mask=%b, required 0000", dut.mask_q);
        end
    endtask

    task automatic test_overrun;
        out_ready = 1'b0;
        scan(pat[1], pat[2], pat[3], pat[4]);
        checks++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h4321 || out_err !== 4'b0000 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL first_frame_held: got v=%b bcd=%h err=%b ovr=%b, required 1 4321 0000 0",
                     out_valid, out_bcd, out_err, overrun);
        end
        scan(pat[5], pat[6], pat[7], pat[8]);
        checks++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h4321 || out_err !== 4'b0000) begin
            errors++;
            $display("FAIL frame_unchanged: got v=%b bcd=%h err=%b, required 1 4321 0000",
                     out_valid, out_bcd, out_err);
        end
        checks++;
        if (overrun !== 1'b1 || dut.mask_q !== '0) begin
            errors++;
            $display("FAIL overrun_set: got ovr=%b mask=%b, required 1 0000", overrun, dut.mask_q);
        end
        idle(1);
        exp_q.push_back({16'h4321, 4'b0000});
        out_ready = 1'b1;
        tick(1);
        checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL drain_after_overrun: got v=%b ovr=%b, required 0 1", out_valid, overrun);
        end
        idle(2);
    endtask

    task automatic test_reset_mid;
        int f0;
        out_ready = 1'b1;
        show_digit(0, pat[2], 6);
        show_digit(1, pat[4], 6);
        show_digit(2, pat[6], 6);
        checks++;
        if (dut.mask_q !== 4'b0111) begin
            errors++;
            $display("FAIL pre_reset_mask: got %b, required 0111", dut.mask_q);
        end
        seg = 7'h00;
        dig_en = '0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || dut.mask_q !== '0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: got v=%b mask=%b ovr=%b, required 0 0000 0",
                     out_valid, dut.mask_q, overrun);
        end
        f0 = frames;
        show_digit(3, pat[8], 6);
        idle(3);
        checks++;
        if (frames != f0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL partial_after_reset: got frames=%0d v=%b, required 0 0",
                     frames - f0, out_valid);
        end
        exp_q.push_back({16'h8531, 4'b0000});
        show_digit(0, pat[1], 6);
        show_digit(1, pat[3], 6);
        show_digit(2, pat[5], 6);
        idle(3);
        checks++;
        if (frames - f0 !== 1) begin
            errors++;
            $display("FAIL full_after_reset: got %0d frames, required 1", frames - f0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_short();
        test_blank();
        test_bad_en();
        test_overrun();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a digit is accepted (legal range 2..15).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, meaning multiplexed digit positions per frame.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port seg  input  7  active-high segments {g,f,e,d,c,b,a}, bit 0 = a.
REQ-006 SHALL have port dig_en  input  NUM_DIGITS  active-high one-hot digit select.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the frame.
REQ-008 SHALL have port out_valid  output  1  captured frame available.
REQ-009 SHALL have port out_bcd  output  4*NUM_DIGITS  decoded digits, digit i in bits [4i+3:4i].
REQ-010 SHALL have port out_err  output  NUM_DIGITS  per-digit invalid-pattern flag.
REQ-011 SHALL have port overrun  output  1  sticky flag: a complete frame was dropped.

Function
REQ-012 SHALL register {seg, dig_en} each cycle into a sample stage and compare with the previous sample.
REQ-013 SHALL count consecutive equal samples in a run counter, saturating at STABLE_CYCLES; a changed sample restarts the count at 1.
REQ-014 SHALL treat a sample with dig_en zero or not one-hot as non-capturable: no slot write; the run counter still counts it.
REQ-015 SHALL write the decoded digit into slot i exactly once per run, on the cycle the counter reaches STABLE_CYCLES with dig_en = one-hot i.
REQ-016 SHALL decode 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F to 0..9 with err=0.
REQ-017 SHALL decode any other pattern, including 0x00 (blank), to 4'hF with err=1.
REQ-018 SHALL keep a captured mask; re-capturing an already-captured slot overwrites its value and err.
REQ-019 SHALL run FSM states EMPTY (mask zero) and COLLECT (mask nonzero, incomplete); a full mask is resolved in the same cycle and never persists.
REQ-020 SHALL, on a full mask, load out_bcd/out_err, set out_valid, and clear the mask, when out_valid=0 or out_valid&out_ready in that cycle.
REQ-021 SHALL otherwise drop the frame, clear the mask, set overrun, and leave out_bcd/out_err unchanged.
REQ-022 SHALL assert out_valid exactly STABLE_CYCLES+1 rising edges after the completing digit's inputs first appear, given an empty output buffer.
REQ-023 SHALL hold out_valid, out_bcd, out_err stable until out_valid&out_ready; then clear out_valid next cycle unless reloaded per REQ-020.
REQ-024 SHALL keep overrun set until reset.

Reset
REQ-025 SHALL, with rst high at a rising edge, clear sample stage, run counter, mask, out_valid, out_bcd, out_err, overrun, and enter EMPTY.
REQ-026 SHALL discard any partial frame and pending output when rst asserts mid-frame; capture restarts from an empty mask.
REQ-027 SHALL require a full new STABLE_CYCLES run after reset release before the first slot write.

Structure
REQ-028 SHALL take the ten digit patterns, blank pattern, invalid code 4'hF and NUM_DIGITS default from shared package seg7_pkg, shared with the existing BCD-to-segment decoder.
REQ-029 SHALL place pattern-to-BCD decoding in one combinational sub-module seg7_pattern_decode (seg in; bcd, err out).

Verification
REQ-030 SHALL verify: scan digits 0..3 with patterns 0x66,0x4F,0x5B,0x06, each held 6 cycles, out_ready=1 -> out_bcd=16'h1234, out_err=0, one out_valid.
REQ-031 SHALL verify: digit 2 held only 3 cycles (STABLE_CYCLES=4) -> no slot write, no out_valid until digit 2 is re-shown for >=4 cycles.
REQ-032 SHALL verify: digit 1 shows 0x00, others valid -> out_bcd[7:4]=4'hF, out_err=4'b0010.
REQ-033 SHALL verify: out_ready=0, two complete frames -> first frame held unchanged, overrun=1 after second completes.
REQ-034 SHALL verify: dig_en=4'b0011 held 10 cycles -> no slot written, mask stays zero.
REQ-035 SHALL verify: rst high one cycle after 3 digits captured -> out_valid=0, mask clear; next frame needs all 4 digits.
